// File: rtl/digit_serial_adder.sv
// ---------------------------------------------------------------------------
// digit_serial_adder
//
// Multi-cycle adder/subtractor that walks the operands DIGIT bits at a time,
// least significant digit first, carrying between digits. A WIDTH-bit
// operation takes WIDTH/DIGIT clock cycles in RUN and ends with a one-cycle
// DONE state in which the result registers are valid.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - request a new operation (accepted in IDLE and DONE)
//   op_a       - operand A (replaced by the current sum when acc_mode=1)
//   op_b       - operand B
//   carry_in   - carry into bit 0 for additions
//   sub        - 1: compute A - B (carry_in ignored)
//   acc_mode   - 1: operand A is the current sum register
//   busy       - high exactly while the operation is in RUN
//   done       - one-cycle pulse; sum/carry_out/overflow valid
//   sum        - result register
//   carry_out  - carry out of the MSB (for subtract, 1 = no borrow)
//   overflow   - two's-complement signed overflow
// ---------------------------------------------------------------------------
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  input  logic             sub,
  input  logic             acc_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  // Reject parameter sets that cannot be split into whole digits.
  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gBadParams
    $error("digit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] opA_q,      opA_d;
  logic [WIDTH-1:0] opB_q,      opB_d;
  logic             carry_q,    carry_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] partial_q,  partial_d;
  logic             aMsb_q,     aMsb_d;
  logic             bMsb_q,     bMsb_d;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic             carryOut_q, carryOut_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] loadA;
  logic [WIDTH-1:0] loadB;
  logic [DIGIT:0]   digitAdd;

  // One digit of the add: the low digit of each shifted operand plus the
  // running carry. Bit DIGIT is the carry into the next digit.
  assign digitAdd = {1'b0, opA_q[DIGIT-1:0]}
                  + {1'b0, opB_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};

  // Next-state and datapath control. Operands are captured on start and then
  // shifted right one digit per RUN cycle, so the live digit is always at
  // the bottom. Each digit result is dropped into its own slot of the
  // partial register; the MSBs of A and B are kept aside for the overflow
  // test because the operand registers are shifted away by the end.
  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    partial_d  = partial_q;
    aMsb_d     = aMsb_q;
    bMsb_d     = bMsb_q;
    sum_d      = sum_q;
    carryOut_d = carryOut_q;
    overflow_d = overflow_q;
    loadA      = acc_mode ? sum_q : op_a;
    loadB      = sub ? ~op_b : op_b;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opA_d     = loadA;
          opB_d     = loadB;
          carry_d   = sub ? 1'b1 : carry_in;
          cnt_d     = '0;
          partial_d = '0;
          aMsb_d    = loadA[WIDTH-1];
          bMsb_d    = loadB[WIDTH-1];
          state_d   = RUN;
        end else begin
          state_d   = IDLE;
        end
      end

      RUN: begin
        opA_d   = opA_q >> DIGIT;
        opB_d   = opB_q >> DIGIT;
        carry_d = digitAdd[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        partial_d[int'(cnt_q) * DIGIT +: DIGIT] = digitAdd[DIGIT-1:0];
        if (cnt_q == LAST_DIGIT) begin
          sum_d      = partial_d;
          carryOut_d = digitAdd[DIGIT];
          overflow_d = (aMsb_q == bMsb_q) && (partial_d[WIDTH-1] != aMsb_q);
          state_d    = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset clears everything immediately, so an
  // operation in flight is simply abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      partial_q  <= '0;
      aMsb_q     <= 1'b0;
      bMsb_q     <= 1'b0;
      sum_q      <= '0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      partial_q  <= partial_d;
      aMsb_q     <= aMsb_d;
      bMsb_q     <= bMsb_d;
      sum_q      <= sum_d;
      carryOut_q <= carryOut_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carryOut_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_digit_serial_adder
//
// Directed bench for digit_serial_adder at WIDTH=16, DIGIT=4. Inputs are
// driven on the falling edge and outputs sampled on the falling edge, half a
// period away from the rising edge the design uses.
// ---------------------------------------------------------------------------
module tb_digit_serial_adder;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             sub;
  logic             acc_mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  int assertCount = 0;
  int failCount   = 0;

  digit_serial_adder #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
    .sub       (sub),
    .acc_mode  (acc_mode),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present an operation at a falling edge, hold start across one rising
  // edge, then scramble the operand pins to show they were latched. Returns
  // at the first falling edge after the start edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic s, input logic acc);
    op_a     = a;
    op_b     = b;
    carry_in = cin;
    sub      = s;
    acc_mode = acc;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    op_a     = ~a;
    op_b     = ~b;
    carry_in = ~cin;
    sub      = ~s;
    acc_mode = 1'b0;
  endtask

  // Follow an operation from the first cycle after its start edge until done,
  // checking latency, busy length and the result. Returns at the falling
  // edge on which done is high (or after the cycle budget runs out).
  task automatic waitDone(input string tag, input logic [WIDTH-1:0] expSum,
                          input logic expCarry, input logic expOvf);
    int cyc;
    int busyCnt;
    checkOutput({tag, " busy after start"}, {31'd0, busy}, 32'd1);
    cyc     = 1;
    busyCnt = 0;
    while (!done && cyc < 20) begin
      busyCnt += int'(busy);
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " done cycle"}, cyc, 32'd5);
    checkOutput({tag, " busy cycles"}, busyCnt, 32'd4);
    checkOutput({tag, " sum"}, {16'd0, sum}, {16'd0, expSum});
    checkOutput({tag, " carry_out"}, {31'd0, carry_out}, {31'd0, expCarry});
    checkOutput({tag, " overflow"}, {31'd0, overflow}, {31'd0, expOvf});
  endtask

  initial begin
    int doneCnt;
    int firstDone;
    logic [WIDTH-1:0] sumAtDone;

    rst_n    = 1'b0;
    start    = 1'b0;
    op_a     = '0;
    op_b     = '0;
    carry_in = 1'b0;
    sub      = 1'b0;
    acc_mode = 1'b0;

    // Reset state
    #12;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset sum", {16'd0, sum}, 32'd0);
    checkOutput("reset carry_out", {31'd0, carry_out}, 32'd0);
    checkOutput("reset overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain add with carry-in
    $display("[TB] plain add");
    applyStimulus(16'h1234, 16'h0FCD, 1'b1, 1'b0, 1'b0);
    waitDone("add", 16'h2202, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("add done one cycle", {31'd0, done}, 32'd0);
    checkOutput("add sum held", {16'd0, sum}, 32'h2202);

    // Wrap-around cases
    $display("[TB] wrap");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    waitDone("wrap unsigned", 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    waitDone("wrap signed", 16'h8000, 1'b0, 1'b1);

    // Subtraction; carry_in must be ignored
    $display("[TB] subtract");
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    waitDone("sub borrow", 16'hFFFE, 1'b0, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    waitDone("sub overflow", 16'h7FFF, 1'b1, 1'b1);

    // Accumulate, started in the done cycle of the previous operation
    $display("[TB] accumulate back-to-back");
    @(negedge clk);
    applyStimulus(16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0);
    waitDone("acc first", 16'h0003, 1'b0, 1'b0);
    applyStimulus(16'hAAAA, 16'h0004, 1'b0, 1'b0, 1'b1);
    waitDone("acc second", 16'h0007, 1'b0, 1'b0);
    @(negedge clk);

    // start pulsed in cycle 2 of RUN must be ignored
    $display("[TB] start while busy");
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    doneCnt   = 0;
    firstDone = 0;
    sumAtDone = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (done) begin
        doneCnt++;
        if (firstDone == 0) begin
          firstDone = cyc;
          sumAtDone = sum;
        end
      end
      if (cyc == 2) begin
        op_a  = 16'hFFFF;
        op_b  = 16'hFFFF;
        start = 1'b1;
      end
      if (cyc == 3) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("ignore start done count", doneCnt, 32'd1);
    checkOutput("ignore start done cycle", firstDone, 32'd5);
    checkOutput("ignore start sum", {16'd0, sumAtDone}, 32'h3333);

    // Asynchronous reset in cycle 2 of RUN
    $display("[TB] reset mid-operation");
    applyStimulus(16'h0100, 16'h0200, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midreset busy before", {31'd0, busy}, 32'd1);
    checkOutput("midreset sum before", {16'd0, sum}, 32'h3333);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset done", {31'd0, done}, 32'd0);
    checkOutput("midreset sum", {16'd0, sum}, 32'd0);
    checkOutput("midreset carry_out", {31'd0, carry_out}, 32'd0);
    checkOutput("midreset overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    doneCnt = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("midreset no done", doneCnt, 32'd0);
    applyStimulus(16'h0100, 16'h0200, 1'b1, 1'b0, 1'b0);
    waitDone("after reset", 16'h0301, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor. It processes DIGIT bits per clock from LSB to MSB and carries the result between digits, so wide adds cost little area on the tile.
- Supports carry-in, subtraction, and an accumulate mode that reuses the last result as operand A.
- Uses a start/busy/done handshake.
- Sits behind the top-level pin wrapper, which maps operands and flags onto the dedicated I/O.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be ≥ 2.
- DIGIT, 4, bits added per cycle. Must divide WIDTH exactly; the elaboration check fails otherwise.

Ports:
- clk        input   1      single clock, rising edge
- rst_n      input   1      asynchronous active-low reset
- start      input   1      request a new operation; sampled on clk
- op_a       input   WIDTH  operand A; ignored when acc_mode=1
- op_b       input   WIDTH  operand B
- carry_in   input   1      carry into bit 0 (add only)
- sub        input   1      1: compute A - B
- acc_mode   input   1      1: operand A := current sum register
- busy       output  1      operation in progress
- done       output  1      one-cycle pulse; results valid
- sum        output  WIDTH  result register
- carry_out  output  1      carry out of MSB (for subtract, 1 = no borrow)
- overflow   output  1      two's-complement signed overflow

Behaviour:
Reset and clocking
- Reset: clk is the single clock; rst_n is asynchronous and active-low. While rst_n=0, state=IDLE and busy, done, sum, carry_out and overflow are all 0.
- Reset mid-operation aborts the operation immediately. No done pulse follows; sum reads 0.

Definitions
- N = WIDTH/DIGIT.
- States: IDLE, RUN, DONE.

IDLE / DONE
- If start=1 at an edge, latch the operands and go to RUN:
  - A = acc_mode ? sum : op_a.
  - B = sub ? ~op_b : op_b.
  - Initial carry c = sub ? 1 : carry_in. carry_in is ignored when sub=1.
  - Load digit counter with 0.
- Otherwise: DONE→IDLE, IDLE stays IDLE.
- start is accepted in the DONE cycle, allowing back-to-back operations with no gap.

RUN
- Each edge adds digit k of A, B and c (a DIGIT-bit add with carry), stores the digit result into the internal shift register, updates c, and increments k.
- At the edge where k = N-1 is processed:
  - sum := full result.
  - carry_out := final c.
  - overflow := (A[MSB] == B[MSB]) && (result[MSB] != A[MSB]), using the latched, possibly inverted, B.
  - State → DONE.
- start is ignored while in RUN. Operands are latched, so input changes during RUN have no effect.

Outputs
- busy = 1 exactly in RUN.
- done = 1 exactly in DONE (one cycle).
- sum, carry_out and overflow change only on the edge entering DONE, or on reset. They hold until the next completion.

Latency
- start sampled at edge 0 → done high in the cycle after edge N.
- busy is high for N cycles.
- DIGIT = WIDTH gives 1-cycle latency.

Arithmetic
- Result is modulo 2^WIDTH.
- Wrap-around is silent; it is reported only via carry_out and overflow.

Test Plan:
All scenarios use WIDTH=16, DIGIT=4.
1. Plain add: start with op_a=0x1234, op_b=0x0FCD, carry_in=1, sub=0 → busy for 4 cycles, done in the 5th cycle after the start edge, sum=0x2202, carry_out=0, overflow=0.
2. Wrap: 0xFFFF+0x0001, carry_in=0 → sum=0x0000, carry_out=1, overflow=0. Then 0x7FFF+0x0001 → sum=0x8000, carry_out=0, overflow=1.
3. Subtract: op_a=0x0005, op_b=0x0007, sub=1, carry_in=1 (ignored) → sum=0xFFFE, carry_out=0, overflow=0. Then 0x8000-0x0001 → sum=0x7FFF, carry_out=1, overflow=1.
4. Accumulate and back-to-back:
   - First, 0x0003+0x0000.
   - In its done cycle, assert start with acc_mode=1, op_a=0xAAAA, op_b=0x0004 → second result sum=0x0007.
   - No idle gap; busy high again in the cycle after done.
5. Start ignored while busy: pulse start with different operands in cycle 2 of RUN → result and timing equal those of the original operation, and there is exactly one done pulse.
6. Reset mid-op: assert rst_n=0 asynchronously in cycle 2 of RUN → busy, done, sum, carry_out and overflow go to 0 without waiting for a clock edge. After release, no done pulse appears, and a new start operates normally.
